mem_access_unit: RTL and testbench

- Load/store unit between the CPU MEM stage and the byte-addressed little-endian data RAM.
- Accepts one load or store request at a time and converts it into a single word-aligned bus access with byte enables.
- Replicates store data onto the correct byte lanes. Extracts and sign- or zero-extends load data.
- Flags misaligned accesses and bus timeouts without touching memory.

---
 rtl/mem_pkg.sv | 36 +++
 rtl/mem_load_extend.sv | 28 ++
 rtl/mem_access_unit.sv | 160 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-memory load/store path.
// Size codes, FSM states, lane-enable and alignment rules.
package mem_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10
   } size_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_RDATA,
      ST_RESP
   } state_e;

   function automatic logic [3:0] byteenable_for(input logic [1:0] size, input logic [1:0] off);
      case (size)
         SZ_BYTE: byteenable_for = 4'b0001 << off;
         SZ_HALF: byteenable_for = 4'b0011 << off;
         default: byteenable_for = 4'b1111;
      endcase
   endfunction

   // The reserved size code never reaches the bus.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      case (size)
         SZ_BYTE: is_misaligned = 1'b0;
         SZ_HALF: is_misaligned = off[0];
         SZ_WORD: is_misaligned = (off != 2'b00);
         default: is_misaligned = 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/mem_load_extend.sv
// Combinational load-data extraction: select the addressed lanes of a
// little-endian bus word and sign- or zero-extend them to 32 bits.
module mem_load_extend
   import mem_pkg::*;
(
   input  logic [31:0] readdata_i,
   input  logic [1:0]  off_i,
   input  logic [1:0]  size_i,
   input  logic        unsigned_i,
   output logic [31:0] result_o
);

   logic [31:0] shifted;
   logic        sign_b;
   logic        sign_h;

   always_comb begin
      shifted = readdata_i >> {off_i, 3'b000};
      sign_b  = ~unsigned_i & shifted[7];
      sign_h  = ~unsigned_i & shifted[15];
      case (size_i)
         SZ_BYTE: result_o = {{24{sign_b}}, shifted[7:0]};
         SZ_HALF: result_o = {{16{sign_h}}, shifted[15:0]};
         default: result_o = shifted;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between the MEM stage and the data RAM: one request at a
// time, turned into a single word-aligned bus access with byte enables.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] mem_address,
   output logic        mem_read,
   output logic        mem_write,
   output logic [3:0]  mem_byteenable,
   output logic [31:0] mem_writedata,
   input  logic [31:0] mem_readdata,
   input  logic        mem_waitrequest
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_e           state_q;
   logic             write_q;
   logic             unsigned_q;
   logic [1:0]       size_q;
   logic [1:0]       off_q;
   logic [CNT_W-1:0] wait_cnt_q;
   logic             req_ready_q;
   logic             resp_valid_q;
   logic             resp_err_q;
   logic [31:0]      resp_rdata_q;
   logic [31:0]      mem_address_q;
   logic             mem_read_q;
   logic             mem_write_q;
   logic [3:0]       mem_byteenable_q;
   logic [31:0]      mem_writedata_q;

   logic [3:0]       byteenable_d;
   logic [31:0]      writedata_d;
   logic             misaligned_d;
   logic [31:0]      load_data_d;

   always_comb begin
      byteenable_d = byteenable_for(req_size, req_addr[1:0]);
      misaligned_d = is_misaligned(req_size, req_addr[1:0]);
      case (req_size)
         SZ_BYTE: writedata_d = {4{req_wdata[7:0]}};
         SZ_HALF: writedata_d = {2{req_wdata[15:0]}};
         default: writedata_d = req_wdata;
      endcase
   end

   mem_load_extend u_extend (
      .readdata_i (mem_readdata),
      .off_i      (off_q),
      .size_i     (size_q),
      .unsigned_i (unsigned_q),
      .result_o   (load_data_d)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= ST_IDLE;
         write_q          <= 1'b0;
         unsigned_q       <= 1'b0;
         size_q           <= 2'b00;
         off_q            <= 2'b00;
         wait_cnt_q       <= '0;
         req_ready_q      <= 1'b1;
         resp_valid_q     <= 1'b0;
         resp_err_q       <= 1'b0;
         resp_rdata_q     <= 32'd0;
         mem_address_q    <= 32'd0;
         mem_read_q       <= 1'b0;
         mem_write_q      <= 1'b0;
         mem_byteenable_q <= 4'd0;
         mem_writedata_q  <= 32'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_valid) begin
                  write_q          <= req_write;
                  unsigned_q       <= req_unsigned;
                  size_q           <= req_size;
                  off_q            <= req_addr[1:0];
                  wait_cnt_q       <= '0;
                  req_ready_q      <= 1'b0;
                  mem_address_q    <= {req_addr[31:2], 2'b00};
                  mem_byteenable_q <= byteenable_d;
                  mem_writedata_q  <= writedata_d;
                  if (misaligned_d) begin
                     state_q      <= ST_RESP;
                     resp_valid_q <= 1'b1;
                     resp_err_q   <= 1'b1;
                  end else begin
                     state_q     <= ST_ACCESS;
                     mem_read_q  <= ~req_write;
                     mem_write_q <= req_write;
                  end
               end
            end
            ST_ACCESS: begin
               if (!mem_waitrequest) begin
                  mem_read_q  <= 1'b0;
                  mem_write_q <= 1'b0;
                  if (write_q) begin
                     state_q      <= ST_RESP;
                     resp_valid_q <= 1'b1;
                  end else begin
                     state_q <= ST_RDATA;
                  end
               end else if (wait_cnt_q == CNT_LAST) begin
                  // Bus never accepted: abandon the access and report it.
                  mem_read_q   <= 1'b0;
                  mem_write_q  <= 1'b0;
                  state_q      <= ST_RESP;
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= 1'b1;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 1'b1;
               end
            end
            ST_RDATA: begin
               resp_rdata_q <= load_data_d;
               resp_valid_q <= 1'b1;
               state_q      <= ST_RESP;
            end
            ST_RESP: begin
               resp_valid_q <= 1'b0;
               resp_err_q   <= 1'b0;
               resp_rdata_q <= 32'd0;
               req_ready_q  <= 1'b1;
               state_q      <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign req_ready      = req_ready_q;
   assign resp_valid     = resp_valid_q;
   assign resp_err       = resp_err_q;
   assign resp_rdata     = resp_rdata_q;
   assign mem_address    = mem_address_q;
   assign mem_read       = mem_read_q;
   assign mem_write      = mem_write_q;
   assign mem_byteenable = mem_byteenable_q;
   assign mem_writedata  = mem_writedata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: bus-side RAM environment plus a byte-level
// reference model of memory, alignment, lane and extension rules.
module tb_mem_access_unit;

   localparam int TMO = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_write, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic [31:0] mem_address, mem_writedata, mem_readdata;
   logic        mem_read, mem_write, mem_waitrequest;
   logic [3:0]  mem_byteenable;

   int checks = 0;
   int errors = 0;

   logic [7:0] ram     [256];
   logic [7:0] ref_mem [256];

   always #5 clk = ~clk;

   mem_access_unit #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_err(resp_err), .mem_address(mem_address), .mem_read(mem_read),
      .mem_write(mem_write), .mem_byteenable(mem_byteenable),
      .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
      .mem_waitrequest(mem_waitrequest)
   );

   function automatic logic exp_mis(input logic [1:0] sz, input logic [31:0] addr);
      if (sz == 2'd3) return 1'b1;
      return (addr % (32'd1 << sz)) != 0;
   endfunction

   function automatic logic [31:0] exp_load(input logic [1:0] sz, input logic uns, input logic [31:0] addr);
      int n = 1 << sz;
      longint v = 0;
      for (int i = 0; i < n; i++)
         v += longint'(ref_mem[int'((addr + 32'(i)) & 32'hFF)]) << (8 * i);
      if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1)))
         v -= longint'(1) << (8 * n);
      return v[31:0];
   endfunction

   function automatic logic [3:0] exp_be(input logic [1:0] sz, input logic [31:0] addr);
      logic [3:0] be = '0;
      for (int i = 0; i < (1 << sz); i++) be[int'(addr % 4) + i] = 1'b1;
      return be;
   endfunction

   function automatic logic [31:0] exp_wd(input logic [1:0] sz, input logic [31:0] wd);
      logic [31:0] r = '0;
      for (int j = 0; j < 4; j++) r[8*j +: 8] = wd[8*(j % (1 << sz)) +: 8];
      return r;
   endfunction

   task automatic ref_store(input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] wd);
      for (int i = 0; i < (1 << sz); i++)
         ref_mem[int'((addr + 32'(i)) & 32'hFF)] = wd[8*i +: 8];
   endtask

   // Drives one request and acts as the RAM; reports what the bus and response showed.
   task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd, input int nwait,
                         output int lat, output logic [31:0] rdata, output logic err,
                         output int strobes, output logic [31:0] a_seen, output logic [3:0] be_seen,
                         output logic [31:0] wd_seen, output logic stable, output logic proto_ok);
      int waits = 0;
      logic rd_pend = 1'b0;
      int base = 0;
      lat = 0; rdata = '0; err = 1'b0; strobes = 0; a_seen = '0; be_seen = '0; wd_seen = '0;
      stable = 1'b1; proto_ok = 1'b1;
      @(negedge clk);
      if (req_ready !== 1'b1) proto_ok = 1'b0;
      req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
      req_addr = addr; req_wdata = wd; mem_waitrequest = 1'b0;
      for (int n = 1; n <= TMO + 40; n++) begin
         @(negedge clk);
         req_write = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
         req_addr = $urandom; req_wdata = $urandom;
         mem_readdata = rd_pend ? {ram[base+3], ram[base+2], ram[base+1], ram[base]} : $urandom;
         rd_pend = 1'b0;
         if (req_ready !== 1'b0) proto_ok = 1'b0;
         if (resp_valid === 1'b1) begin
            lat = n; rdata = resp_rdata; err = resp_err; req_valid = 1'b0;
            break;
         end
         if (mem_read === 1'b1 || mem_write === 1'b1) begin
            if (strobes == 0) begin
               a_seen = mem_address; be_seen = mem_byteenable; wd_seen = mem_writedata;
            end else if (mem_address !== a_seen || mem_byteenable !== be_seen || mem_writedata !== wd_seen) begin
               stable = 1'b0;
            end
            if (mem_read === wr || mem_write !== wr) proto_ok = 1'b0;
            strobes++;
            if (waits < nwait) begin
               mem_waitrequest = 1'b1;
               waits++;
            end else begin
               mem_waitrequest = 1'b0;
               base = int'(mem_address[7:2]) * 4;
               if (mem_write === 1'b1) begin
                  for (int k = 0; k < 4; k++)
                     if (mem_byteenable[k]) ram[base+k] = mem_writedata[8*k +: 8];
               end else begin
                  rd_pend = 1'b1;
               end
            end
         end else begin
            mem_waitrequest = 1'($urandom);
         end
      end
      req_valid = 1'b0;
      @(negedge clk);
      if (resp_valid !== 1'b0 || req_ready !== 1'b1 || mem_read !== 1'b0 || mem_write !== 1'b0)
         proto_ok = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
      req_addr = '0; req_wdata = '0; mem_readdata = '0; mem_waitrequest = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (req_ready !== 1'b1) begin
         errors++; $display("FAIL reset_ready got %b want 1", req_ready);
      end
      checks++;
      if ({resp_valid, resp_err, mem_read, mem_write, mem_byteenable} !== 8'd0) begin
         errors++; $display("FAIL reset_ctrl got %b want 00000000",
                             {resp_valid, resp_err, mem_read, mem_write, mem_byteenable});
      end
      checks++;
      if ({resp_rdata, mem_address, mem_writedata} !== 96'd0) begin
         errors++; $display("FAIL reset_data rdata %h addr %h wdata %h want all 0",
                             resp_rdata, mem_address, mem_writedata);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_store_load();
      int lat, strb; logic [31:0] rd, a, wd; logic err, stb, ok; logic [3:0] be;
      do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0, lat, rd, err, strb, a, be, wd, stb, ok);
      ref_store(2'd2, 32'h10, 32'hDEADBEEF);
      checks++;
      if (be !== 4'b1111 || wd !== 32'hDEADBEEF || a !== 32'h10 || strb != 1) begin
         errors++; $display("FAIL sw_bus be %b wd %h addr %h strobes %0d want 1111 DEADBEEF 10 1", be, wd, a, strb);
      end
      checks++;
      if (lat != 2 || err !== 1'b0 || rd !== 32'd0 || !ok) begin
         errors++; $display("FAIL sw_resp lat %0d err %b rdata %h ok %b want 2 0 0 1", lat, err, rd, ok);
      end
      do_req(1'b1, 2'd0, 1'b0, 32'h13, 32'h000000A5, 0, lat, rd, err, strb, a, be, wd, stb, ok);
      ref_store(2'd0, 32'h13, 32'h000000A5);
      checks++;
      if (be !== 4'b1000 || wd !== 32'hA5A5A5A5 || a !== 32'h10 || lat != 2) begin
         errors++; $display("FAIL sb_bus be %b wd %h addr %h lat %0d want 1000 A5A5A5A5 10 2", be, wd, a, lat);
      end
      do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, lat, rd, err, strb, a, be, wd, stb, ok);
      checks++;
      if (rd !== 32'hA5ADBEEF || lat != 3 || err !== 1'b0 || !ok) begin
         errors++; $display("FAIL lw_after_sb rdata %h lat %0d err %b want A5ADBEEF 3 0", rd, lat, err);
      end
   endtask

   task automatic test_signed_loads();
      int lat, strb; logic [31:0] rd, a, wd; logic err, stb, ok; logic [3:0] be;
      logic [1:0]  sz  [4] = '{2'd0, 2'd0, 2'd1, 2'd1};
      logic        uns [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      logic [31:0] ad  [4] = '{32'h22, 32'h23, 32'h22, 32'h20};
      logic [31:0] exv [4] = '{32'hFFFFFFFF, 32'h00000080, 32'hFFFF80FF, 32'h00007F01};
      do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'h80FF7F01, 0, lat, rd, err, strb, a, be, wd, stb, ok);
      ref_store(2'd2, 32'h20, 32'h80FF7F01);
      for (int i = 0; i < 4; i++) begin
         do_req(1'b0, sz[i], uns[i], ad[i], 32'h0, 0, lat, rd, err, strb, a, be, wd, stb, ok);
         checks++;
         if (rd !== exv[i] || err !== 1'b0 || lat != 3) begin
            errors++; $display("FAIL ext_load%0d rdata %h err %b lat %0d want %h 0 3", i, rd, err, lat, exv[i]);
         end
      end
   endtask

   task automatic test_misaligned();
      int lat, strb; logic [31:0] rd, a, wd; logic err, stb, ok; logic [3:0] be;
      logic [1:0]  sz [2] = '{2'd2, 2'd1};
      logic [31:0] ad [2] = '{32'h21, 32'h23};
      for (int i = 0; i < 2; i++) begin
         do_req(1'b0, sz[i], 1'b0, ad[i], 32'h0, 0, lat, rd, err, strb, a, be, wd, stb, ok);
         checks++;
         if (lat != 1 || err !== 1'b1 || rd !== 32'd0 || strb != 0 || !ok) begin
            errors++; $display("FAIL misaligned%0d lat %0d err %b rdata %h strobes %0d want 1 1 0 0", i, lat, err, rd, strb);
         end
      end
   endtask

   task automatic test_waitrequest();
      int lat, strb; logic [31:0] rd, a, wd; logic err, stb, ok; logic [3:0] be;
      do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 5, lat, rd, err, strb, a, be, wd, stb, ok);
      checks++;
      if (lat != 8 || strb != 6 || !stb || a !== 32'h20 || rd !== 32'h80FF7F01 || err !== 1'b0) begin
         errors++; $display("FAIL wait5 lat %0d strobes %0d stable %b addr %h rdata %h err %b want 8 6 1 20 80FF7F01 0",
                             lat, strb, stb, a, rd, err);
      end
   endtask

   task automatic test_timeout();
      int lat, strb; logic [31:0] rd, a, wd; logic err, stb, ok; logic [3:0] be;
      do_req(1'b0, 2'd2, 1'b0, 32'h24, 32'h0, 100000, lat, rd, err, strb, a, be, wd, stb, ok);
      checks++;
      if (lat != TMO + 1 || strb != TMO || err !== 1'b1 || rd !== 32'd0 || !ok) begin
         errors++; $display("FAIL timeout lat %0d strobes %0d err %b rdata %h want %0d %0d 1 0",
                             lat, strb, err, rd, TMO + 1, TMO);
      end
   endtask

   task automatic test_reset_mid_access();
      int lat, strb; logic [31:0] rd, a, wd; logic err, stb, ok, seen; logic [3:0] be;
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 32'h40; mem_waitrequest = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (mem_read !== 1'b1) begin
         errors++; $display("FAIL rst_pre_read got %b want 1", mem_read);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (mem_read !== 1'b0 || req_ready !== 1'b1) begin
         errors++; $display("FAIL rst_async read %b ready %b want 0 1", mem_read, req_ready);
      end
      seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (resp_valid !== 1'b0) seen = 1'b1;
      end
      mem_waitrequest = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      if (resp_valid !== 1'b0) seen = 1'b1;
      checks++;
      if (seen) begin
         errors++; $display("FAIL rst_no_resp got resp_valid 1 want 0");
      end
      do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0, lat, rd, err, strb, a, be, wd, stb, ok);
      checks++;
      if (lat != 3 || rd !== exp_load(2'd2, 1'b0, 32'h20) || err !== 1'b0 || !ok) begin
         errors++; $display("FAIL rst_then_lw lat %0d rdata %h err %b want 3 %h 0",
                             lat, rd, err, exp_load(2'd2, 1'b0, 32'h20));
      end
   endtask

   task automatic test_random();
      int lat, strb, nw, elat, estr; logic [31:0] rd, a, wd, addr, wdat, erd; logic err, stb, ok, mis;
      logic [3:0] be; logic wr, uns; logic [1:0] sz;
      for (int t = 0; t < 60; t++) begin
         wr = 1'($urandom); uns = 1'($urandom); sz = 2'($urandom);
         addr = ($urandom & 32'hFFFF_FF00) | ($urandom % 256);
         wdat = $urandom;
         nw = ($urandom % 4 == 0) ? int'($urandom % 4) : 0;
         mis  = exp_mis(sz, addr);
         elat = mis ? 1 : (wr ? 2 + nw : 3 + nw);
         estr = mis ? 0 : nw + 1;
         erd  = (mis || wr) ? 32'd0 : exp_load(sz, uns, addr);
         do_req(wr, sz, uns, addr, wdat, nw, lat, rd, err, strb, a, be, wd, stb, ok);
         if (!mis && wr) ref_store(sz, addr, wdat);
         checks++;
         if (err !== mis || lat != elat || rd !== erd) begin
            errors++; $display("FAIL rand%0d_resp err %b lat %0d rdata %h want %b %0d %h",
                                t, err, lat, rd, mis, elat, erd);
         end
         checks++;
         if (strb != estr || !stb || !ok) begin
            errors++; $display("FAIL rand%0d_proto strobes %0d stable %b ok %b want %0d 1 1", t, strb, stb, ok, estr);
         end
         if (!mis) begin
            checks++;
            if (a !== (addr & ~32'h3) || be !== exp_be(sz, addr)) begin
               errors++; $display("FAIL rand%0d_addr addr %h be %b want %h %b",
                                   t, a, be, addr & ~32'h3, exp_be(sz, addr));
            end
            if (wr) begin
               checks++;
               if (wd !== exp_wd(sz, wdat)) begin
                  errors++; $display("FAIL rand%0d_wdata got %h want %h", t, wd, exp_wd(sz, wdat));
               end
            end
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         ram[i] = 8'($urandom);
         ref_mem[i] = ram[i];
      end
      test_reset();
      test_store_load();
      test_signed_loads();
      test_misaligned();
      test_waitrequest();
      test_timeout();
      test_reset_mid_access();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
